// File: rtl/sram_freeze_ctrl_if.sv
// Bundles the pipeline-side request bus and the 16-bit asynchronous SRAM pins of sram_freeze_ctrl.
// The slave modport is the controller; the master modport is the pipeline/SRAM side.
interface sram_freeze_ctrl_if #(
    parameter int unsigned SRAM_AW = 18
);
    logic               rd_en;
    logic               wr_en;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic               freeze;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_ce_n;
    logic               sram_oe_n;
    logic               sram_we_n;

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, freeze, sram_addr, sram_dq_out,
               sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
    );

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, freeze, sram_addr, sram_dq_out,
               sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/sram_freeze_ctrl.sv
// MEM-stage controller that splits 32-bit accesses into two 16-bit SRAM halves and freezes the pipeline meanwhile.
// Optional `SRAM_STALL_CNT_EN adds a saturating stall_cycles counter output.
module sram_freeze_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic              clk,
    input  logic              rst,
    sram_freeze_ctrl_if.slave bus
`ifdef SRAM_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);
    localparam int unsigned WORD_W     = SRAM_AW - 1;
    localparam logic [3:0]  CNT_RELOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic               is_wr_q;
    logic [15:0]        wdata_hi_q;
    logic [31:0]        rdata_q;
    logic [SRAM_AW-1:0] sram_addr_q;
    logic [15:0]        dq_out_q;
    logic               dq_oe_q;
    logic               ce_n_q;
    logic               oe_n_q;
    logic               we_n_q;

    logic               req_c;
    logic               ready_c;
    logic               freeze_c;
    logic [WORD_W-1:0]  word_c;

    assign req_c  = bus.rd_en | bus.wr_en;
    assign word_c = WORD_W'((bus.address - ADDR_BASE) >> 2);

    // ready/freeze must react to a new request in the same cycle it appears
    always_comb begin
        ready_c  = 1'b0;
        freeze_c = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c  = ~req_c;
                freeze_c = req_c;
            end
            LOW, HIGH: freeze_c = 1'b1;
            DONE:      ready_c  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            is_wr_q     <= 1'b0;
            wdata_hi_q  <= 16'd0;
            rdata_q     <= 32'd0;
            sram_addr_q <= '0;
            dq_out_q    <= 16'd0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_c) begin
                        is_wr_q     <= bus.wr_en;
                        wdata_hi_q  <= bus.write_data[31:16];
                        cnt_q       <= CNT_RELOAD;
                        state_q     <= LOW;
                        sram_addr_q <= {word_c, 1'b0};
                        ce_n_q      <= 1'b0;
                        oe_n_q      <= bus.wr_en;
                        we_n_q      <= ~bus.wr_en;
                        dq_oe_q     <= bus.wr_en;
                        if (bus.wr_en) dq_out_q <= bus.write_data[15:0];
                    end
                end
                LOW: begin
                    if (cnt_q == 4'd0) begin
                        if (!is_wr_q) rdata_q[15:0] <= bus.sram_dq_in;
                        if (is_wr_q)  dq_out_q      <= wdata_hi_q;
                        cnt_q          <= CNT_RELOAD;
                        sram_addr_q[0] <= 1'b1;
                        state_q        <= HIGH;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                HIGH: begin
                    if (cnt_q == 4'd0) begin
                        if (!is_wr_q) rdata_q[31:16] <= bus.sram_dq_in;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end

`ifdef SRAM_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else if (freeze_c && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
`endif

    assign bus.read_data   = rdata_q;
    assign bus.ready       = ready_c;
    assign bus.freeze      = freeze_c;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_ce_n   = ce_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.sram_we_n   = we_n_q;
endmodule

// File: tb/tb_sram_freeze_ctrl.sv
// Self-checking bench for sram_freeze_ctrl: per-cycle expected bus snapshots are queued when a request
// is launched and popped as the DUT runs; a small SRAM model sits on the pins.
module tb_sram_freeze_ctrl;
    localparam int unsigned W    = 2;
    localparam int unsigned BASE = 1024;
    localparam int unsigned AW   = 18;

    typedef struct packed {
        logic          ready;
        logic          freeze;
        logic          ce_n;
        logic          oe_n;
        logic          we_n;
        logic          dq_oe;
        logic [AW-1:0] addr;
        logic [15:0]   dq;
        logic [31:0]   rdata;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    obs_t        sb[$];
    logic [15:0] sram_mem [0:63];
    logic [15:0] shadow [int];
    logic [AW-1:0] m_addr;
    logic [15:0]   m_dq;
    logic [31:0]   m_rdata;

    sram_freeze_ctrl_if #(.SRAM_AW(AW)) bus ();
`ifdef SRAM_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    sram_freeze_ctrl #(.WAIT_CYCLES(W), .ADDR_BASE(BASE), .SRAM_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SRAM_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // asynchronous SRAM: read data while selected and output-enabled, write on strobed edges
    assign bus.sram_dq_in = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram_mem[bus.sram_addr[5:0]] : 16'h0000;
    always @(posedge clk) begin
        if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe)
            sram_mem[bus.sram_addr[5:0]] <= bus.sram_dq_out;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic obs_t pack_obs();
        return {bus.ready, bus.freeze, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n,
                bus.sram_dq_oe, bus.sram_addr, bus.sram_dq_out, bus.read_data};
    endfunction

    task automatic sample(output obs_t o);
        @(negedge clk);
        o = pack_obs();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_idle();
        sb.push_back({1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, m_addr, m_dq, m_rdata});
    endtask

    // expected snapshots for one access: IDLE-detect, W LOW, W HIGH, DONE
    task automatic push_access(input logic isw, input logic [31:0] a, input logic [31:0] wd);
        logic [AW-2:0] word;
        logic [AW-1:0] lo, hi;
        logic [31:0]   rv;
        word = (AW-1)'((a - BASE) >> 2);
        lo = {word, 1'b0};
        hi = {word, 1'b1};
        if (isw) begin
            shadow[int'(lo)] = wd[15:0];
            shadow[int'(hi)] = wd[31:16];
        end
        rv[15:0]  = shadow.exists(int'(lo)) ? shadow[int'(lo)] : 16'h0000;
        rv[31:16] = shadow.exists(int'(hi)) ? shadow[int'(hi)] : 16'h0000;
        sb.push_back({1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, m_addr, m_dq, m_rdata});
        if (isw) m_dq = wd[15:0];
        for (int i = 0; i < W; i++)
            sb.push_back({1'b0, 1'b1, 1'b0, isw, ~isw, isw, lo, m_dq, m_rdata});
        if (!isw) m_rdata[15:0] = rv[15:0];
        if (isw) m_dq = wd[31:16];
        for (int i = 0; i < W; i++)
            sb.push_back({1'b0, 1'b1, 1'b0, isw, ~isw, isw, hi, m_dq, m_rdata});
        if (!isw) m_rdata[31:16] = rv[31:16];
        m_addr = hi;
        sb.push_back({1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, m_addr, m_dq, m_rdata});
    endtask

    task automatic test_reset();
        obs_t o, e;
        push_idle();
        sample(o);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL reset_held got %h want %h", o, e); end
        next_cycle();
        rst = 1'b0;
        push_idle();
        sample(o);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL reset_release got %h want %h", o, e); end
        next_cycle();
`ifdef SRAM_STALL_CNT_EN
        n_cmp++;
        if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL stall_reset got %0d want 0", stall_cycles); end
`endif
    endtask

    task automatic test_write();
        obs_t o, e;
        push_access(1'b1, 32'd1028, 32'hDEAD_BEEF);
        bus.wr_en = 1'b1; bus.address = 32'd1028; bus.write_data = 32'hDEAD_BEEF;
        for (int c = 0; sb.size() > 0; c++) begin
            sample(o);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL write c%0d got %h want %h", c, o, e); end
            next_cycle();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic test_read_back();
        obs_t o, e;
        push_access(1'b0, 32'd1028, 32'h0);
        bus.rd_en = 1'b1; bus.address = 32'd1028; bus.write_data = 32'h0;
        for (int c = 0; sb.size() > 0; c++) begin
            sample(o);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL read c%0d got %h want %h", c, o, e); end
            next_cycle();
        end
        bus.rd_en = 1'b0;
        n_cmp++;
        if (bus.read_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL read_value got %h want deadbeef", bus.read_data);
        end
`ifdef SRAM_STALL_CNT_EN
        n_cmp++;
        if (stall_cycles !== 32'd10) begin n_fail++; $display("FAIL stall_b2b got %0d want 10", stall_cycles); end
`endif
    endtask

    task automatic test_both_is_write();
        obs_t o, e;
        push_access(1'b1, 32'd1024, 32'h1234_5678);
        bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.address = 32'd1024; bus.write_data = 32'h1234_5678;
        for (int c = 0; sb.size() > 0; c++) begin
            sample(o);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL both c%0d got %h want %h", c, o, e); end
            next_cycle();
        end
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        n_cmp++;
        if (sram_mem[0] !== 16'h5678) begin n_fail++; $display("FAIL both_mem0 got %h want 5678", sram_mem[0]); end
        n_cmp++;
        if (sram_mem[1] !== 16'h1234) begin n_fail++; $display("FAIL both_mem1 got %h want 1234", sram_mem[1]); end
    endtask

    task automatic test_drop_misaligned();
        obs_t o, e;
        push_access(1'b1, 32'd1036, 32'hA5A5_5A5A);
        bus.wr_en = 1'b1; bus.address = 32'd1036; bus.write_data = 32'hA5A5_5A5A;
        for (int c = 0; sb.size() > 0; c++) begin
            sample(o);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL drop_wr c%0d got %h want %h", c, o, e); end
            next_cycle();
            if (c == 0) bus.wr_en = 1'b0;
        end
        push_access(1'b0, 32'd1039, 32'h0);
        push_idle();
        bus.rd_en = 1'b1; bus.address = 32'd1039;
        for (int c = 0; sb.size() > 0; c++) begin
            sample(o);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL drop_rd c%0d got %h want %h", c, o, e); end
            next_cycle();
            if (c == 0) bus.rd_en = 1'b0;
        end
    endtask

    task automatic test_reset_mid_access();
        obs_t o, e;
        bus.wr_en = 1'b1; bus.address = 32'd1040; bus.write_data = 32'hCAFE_F00D;
        repeat (3) next_cycle();
        o = pack_obs();
        e = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 18'd9, 16'hCAFE, m_rdata};
        n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL mid_high got %h want %h", o, e); end
        rst = 1'b1;
        bus.wr_en = 1'b0;
        #1;
        m_addr = '0; m_dq = 16'h0; m_rdata = 32'h0;
        o = pack_obs();
        e = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, m_addr, m_dq, m_rdata};
        n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL mid_reset got %h want %h", o, e); end
        next_cycle();
        rst = 1'b0;
        push_idle();
        sample(o);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL mid_after got %h want %h", o, e); end
`ifdef SRAM_STALL_CNT_EN
        n_cmp++;
        if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL stall_cleared got %0d want 0", stall_cycles); end
`endif
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        bus.address = 32'h0; bus.write_data = 32'h0;
        m_addr = '0; m_dq = 16'h0; m_rdata = 32'h0;
        for (int i = 0; i < 64; i++) sram_mem[i] = 16'h0000;
        #1;
        test_reset();
        test_write();
        test_read_back();
        test_both_is_write();
        test_drop_misaligned();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_freeze_ctrl.md
Name: sram_freeze_ctrl

Overview:
- Multi-cycle controller between the MEM stage and an external 16-bit asynchronous SRAM.
- Each 32-bit load or store is split into two 16-bit halves, each held for WAIT_CYCLES cycles.
- Drives the pipeline-wide freeze, so every stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) holds until the access completes.
- Sits beside the MEM stage. freeze is routed to every pipeline register's Freeze input.

Parameters:
- WAIT_CYCLES, 2, cycles each 16-bit half is held on the SRAM bus; legal range 1..15.
- ADDR_BASE, 1024, byte address that maps to SRAM word 0.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- rd_en  in  1  load request (MEM_Read of EX/MEM)
- wr_en  in  1  store request (MEM_Write of EX/MEM)
- address  in  32  byte address from ALU result
- write_data  in  32  store data
- read_data  out  32  load data, registered
- ready  out  1  access complete / controller free
- freeze  out  1  stall all pipeline registers
- sram_addr  out  SRAM_AW  half-word address
- sram_dq_out  out  16  data driven to SRAM
- sram_dq_in  in  16  data sampled from SRAM
- sram_dq_oe  out  1  tri-state enable for sram_dq_out
- sram_ce_n  out  1  chip enable, active-low
- sram_oe_n  out  1  output enable, active-low
- sram_we_n  out  1  write enable, active-low

Behaviour:
- Reset (asynchronous, takes effect immediately, even mid-access):
  - state=IDLE, counter=0, latched op cleared, read_data=0.
  - Outputs: sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
- Address map:
  - word = (address - ADDR_BASE) >> 2, truncated to SRAM_AW-1 bits.
  - sram_addr = {word, half}; half=0 selects bits [15:0], half=1 selects bits [31:16].
  - address[1:0] is ignored.
- req = rd_en | wr_en. If both are high, the access is a write; the read is ignored.
- FSM states are IDLE, LOW, HIGH, DONE. counter is 4 bits.
- IDLE:
  - ready = ~req.
  - If req: latch op (write/read), address, write_data; counter <= WAIT_CYCLES-1; go to LOW.
- LOW:
  - sram_addr half=0, sram_ce_n=0.
  - Write: sram_we_n=0, sram_dq_oe=1, sram_dq_out = write_data[15:0].
  - Read: sram_oe_n=0; on the cycle with counter==0, read_data[15:0] <= sram_dq_in.
  - counter decrements each cycle. At counter==0: reload to WAIT_CYCLES-1, go to HIGH.
- HIGH:
  - Same as LOW, but half=1, using write_data[31:16] and read_data[31:16].
  - At counter==0: go to DONE.
- DONE:
  - ready=1 for exactly one cycle; SRAM idle (all strobes high, dq_oe=0).
  - Pipeline advances on this edge; next state is IDLE unconditionally.
- freeze = req & ~ready, combinational.
  - In LOW/HIGH, freeze=1 regardless of inputs.
- Latency: request seen in IDLE at cycle 0.
  - freeze is high cycles 0 .. 2*WAIT_CYCLES.
  - ready is high in cycle 2*WAIT_CYCLES+1.
  - With WAIT_CYCLES=2: 5 freeze cycles, ready at cycle 5.
- No request: ready=1, freeze=0, SRAM idle every cycle.
- Request dropped mid-access (rd_en/wr_en fall in LOW/HIGH): the access completes using the latched op; no abort.
- read_data holds its last value through writes and idle cycles.
- Back-to-back accesses: DONE→IDLE costs no extra cycle beyond the IDLE detection cycle.

Optional Feature:
SRAM_STALL_CNT_EN:
- Defined: adds output stall_cycles (32 bits, reset 0).
  - Increments every cycle freeze=1; saturates at 0xFFFFFFFF.
  - Cleared only by rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset (WAIT_CYCLES=2, ADDR_BASE=1024) → rst=1 with rd_en=wr_en=0 → ready=1, freeze=0, read_data=0, ce_n=oe_n=we_n=1, dq_oe=0.
2. Write: wr_en=1, address=1028, write_data=0xDEADBEEF at cycle 0 → cycles 1-2 sram_addr=2, dq_out=0xBEEF, we_n=0; cycles 3-4 sram_addr=3, dq_out=0xDEAD; freeze=1 cycles 0-4; ready=1 cycle 5.
3. Read-back: rd_en=1, address=1028, SRAM model holds the data from scenario 2 → oe_n=0 cycles 1-4, read_data=0xDEADBEEF from cycle 5, ready=1 cycle 5, we_n stays 1.
4. rd_en=wr_en=1, address=1024, write_data=0x12345678 → write performed (addr 0 ← 0x5678, addr 1 ← 0x1234); read_data unchanged.
5. rst asserted during HIGH of a write → same cycle: we_n=1, dq_oe=0, state=IDLE; after release with no request, ready=1.
6. With SRAM_STALL_CNT_EN: run scenario 2 then scenario 3 back-to-back → stall_cycles=10.
